// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU-side initiator and mem_responder.
// master = initiator (CPU controller/datapath), slave = mem_responder.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWrite;
    logic [ADDR_WIDTH-1:0] ReqAddr;
    logic [DATA_WIDTH-1:0] ReqData;
    logic                  RespValid;
    logic                  RespReady;
    logic [DATA_WIDTH-1:0] RespData;
    logic                  RespErr;
    logic                  Busy;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
        input  ReqReady, RespValid, RespData, RespErr, Busy
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, RespReady,
        output ReqReady, RespValid, RespData, RespErr, Busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write request, inserts
// WAIT_CYCLES wait states, performs the access, then holds the response
// until the initiator takes it.
// Optional feature: define MEM_RESP_ADDR_CHECK_EN to flag addresses >= DEPTH
// as errors (write suppressed, RespData 0, RespErr 1). Without it DEPTH must
// be 2**ADDR_WIDTH and RespErr is tied 0.
module mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t                state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic                  write_q,     write_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q,  resp_err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  addr_ok;
    logic                  mem_we;

`ifdef MEM_RESP_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    assign addr_ok = ({1'b0, addr_q} < DEPTH_W);
`else
    assign addr_ok = 1'b1;
`endif

    assign mem_rdata = mem[addr_q];
    assign mem_we    = (state_q == S_ACCESS) && write_q && addr_ok;

    assign bus.ReqReady  = (state_q == S_IDLE);
    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.RespValid = (state_q == S_RESP);
    assign bus.RespData  = resp_data_q;
    assign bus.RespErr   = resp_err_q;

    // Next-state and next-output computation for the request/response FSM.
    always_comb begin
        // NOTE: every _d gets its current value first so no path through the case leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.ReqValid) begin
                    write_d = bus.ReqWrite;
                    addr_d  = bus.ReqAddr;
                    wdata_d = bus.ReqData;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_LOAD != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // cnt_q == 0 cannot occur here; treating it like 1 keeps the FSM from stalling.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                resp_data_d = write_q ? wdata_q : mem_rdata;
                resp_err_d  = 1'b0;
                if (!addr_ok) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.RespReady) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, request latches and response registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Storage array, written at the ACCESS edge of an in-range write.
    always_ff @(posedge Clk) begin
        // NOTE: the array has no reset; contents survive Reset and it maps onto plain RAM.
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule
